multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM (R-type, ORI, LW, SW, BEQ, JAL) with a
// sticky illegal-opcode trap.
// Ports:
//   clk, rst_n (sync, active-low)    -- clock and reset
//   op[5:0], zero, mem_ready         -- IR opcode, ALU zero flag, memory handshake
//   mem_req, mem_we, i_or_d          -- memory request / write / address select
//   ir_write, pc_write, pc_write_cond, pc_src[1:0] -- IR and PC update controls
//   alu_src_a, alu_src_b[1:0], alu_op[ALU_OP_W-1:0], extend_op -- ALU controls
//   reg_write, reg_dst, mem_to_reg, link           -- register file controls
//   illegal_op, state[3:0]           -- sticky trap flag and debug state
module multicycle_controller #(
  parameter int unsigned ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                extend_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                link,
  output logic                illegal_op,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_ORI = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_FUNCT = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_e state_q, state_d;
  logic   reg_dst_q, reg_dst_d;   // 1 when the pending ALU writeback is R-type
  logic   is_lw_q, is_lw_d;       // load vs store, latched at decode
  logic   illegal_q, illegal_d;

  // zero is gated with pc_write_cond in the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  // State and flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      reg_dst_q <= 1'b0;
      is_lw_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_dst_q <= reg_dst_d;
      is_lw_q   <= is_lw_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d       = state_q;
    reg_dst_d     = reg_dst_q;
    is_lw_d       = is_lw_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_OP_W'(ALU_ADD);
    extend_op     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    link          = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        extend_op = 1'b1;
        is_lw_d   = (op == OP_LW);
        case (op)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ORI:       state_d = S_EXEC_ORI;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_JAL:       state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_W'(ALU_FUNCT);
        reg_dst_d = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_EXEC_ORI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_OP_W'(ALU_OR);
        reg_dst_d = 1'b0;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = reg_dst_q;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        extend_op = 1'b1;
        state_d   = is_lw_q ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_W'(ALU_SUB);
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = 2'b10;
        reg_write = 1'b1;
        link      = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Sticky: once the trap is entered only reset clears it
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a default build (u_a) and an
// ALU_OP_W=4 build (u_b) run the same stimulus in lockstep.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       a_mem_req, a_mem_we, a_i_or_d, a_ir_write, a_pc_write, a_pc_write_cond;
  logic [1:0] a_pc_src, a_alu_src_b, a_alu_op;
  logic       a_alu_src_a, a_extend_op, a_reg_write, a_reg_dst, a_mem_to_reg, a_link;
  logic       a_illegal_op;
  logic [3:0] a_state;

  logic       b_mem_req, b_mem_we, b_i_or_d, b_ir_write, b_pc_write, b_pc_write_cond;
  logic [1:0] b_pc_src, b_alu_src_b;
  logic [3:0] b_alu_op;
  logic       b_alu_src_a, b_extend_op, b_reg_write, b_reg_dst, b_mem_to_reg, b_link;
  logic       b_illegal_op;
  logic [3:0] b_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_controller u_a (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .i_or_d(a_i_or_d),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond),
    .pc_src(a_pc_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .extend_op(a_extend_op), .reg_write(a_reg_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .link(a_link),
    .illegal_op(a_illegal_op), .state(a_state)
  );

  multicycle_controller #(.ALU_OP_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .i_or_d(b_i_or_d),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
    .pc_src(b_pc_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .extend_op(b_extend_op), .reg_write(b_reg_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .link(b_link),
    .illegal_op(b_illegal_op), .state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, confirm builds agree
  task automatic tick();
    @(posedge clk);
    #1;
    chk("lockstep",
        {b_state, b_mem_req, b_mem_we, b_i_or_d, b_ir_write, b_pc_write, b_pc_write_cond,
         b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_extend_op, b_reg_write,
         b_reg_dst, b_mem_to_reg, b_link, b_illegal_op},
        {a_state, a_mem_req, a_mem_we, a_i_or_d, a_ir_write, a_pc_write, a_pc_write_cond,
         a_pc_src, a_alu_src_a, a_alu_src_b, 4'(a_alu_op), a_extend_op, a_reg_write,
         a_reg_dst, a_mem_to_reg, a_link, a_illegal_op});
  endtask

  initial begin
    rst_n = 1'b0; op = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_illegal", 32'(a_illegal_op), 32'd0);
    chk("rst_mem_req", 32'(a_mem_req), 32'd1);

    // FETCH wait, then R-type: 0,1,2,8,0
    rst_n = 1'b1;
    tick();
    chk("fetch_wait_state", 32'(a_state), 32'd0);
    chk("fetch_wait_ir", 32'({a_ir_write, a_pc_write, a_mem_req, a_i_or_d}), 32'b0010);
    tick();
    chk("fetch_wait2_ir", 32'(a_ir_write), 32'd0);
    mem_ready = 1'b1; #1;
    chk("fetch_ready", 32'({a_ir_write, a_pc_write, a_alu_src_b}), 32'b1101);
    tick();
    chk("r_decode", 32'({a_state, a_alu_src_a, a_alu_src_b, a_extend_op}), {4'd1, 4'b0101});
    tick();
    chk("r_exec", 32'({a_state, a_alu_src_a, a_alu_src_b, a_alu_op}), {4'd2, 5'b10011});
    tick();
    chk("r_wb", 32'({a_state, a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_op}), {4'd8, 5'b11000});
    tick();
    chk("r_done", 32'(a_state), 32'd0);

    // LW with three not-ready cycles in MEM_RD
    op = 6'b100011;
    tick(); chk("lw_decode", 32'(a_state), 32'd1);
    tick(); chk("lw_addr", 32'({a_state, a_alu_src_a, a_alu_src_b, a_extend_op}), {4'd4, 4'b1101});
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_rd_wait", 32'({a_state, a_mem_req, a_i_or_d, a_mem_we}), {4'd5, 3'b110});
      tick();
    end
    chk("lw_rd_4th", 32'(a_state), 32'd5);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb", 32'({a_state, a_reg_write, a_mem_to_reg, a_reg_dst}), {4'd6, 3'b110});
    tick(); chk("lw_done", 32'(a_state), 32'd0);

    // SW, no wait: 0,1,4,7,0
    op = 6'b101011;
    tick(); tick();
    chk("sw_addr", 32'(a_state), 32'd4);
    tick();
    chk("sw_wr", 32'({a_state, a_mem_req, a_mem_we, a_i_or_d}), {4'd7, 3'b111});
    tick(); chk("sw_done", 32'(a_state), 32'd0);

    // SW stuck in MEM_WR, then reset
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    chk("sw_wait", 32'({a_state, a_mem_we}), {4'd7, 1'b1});
    rst_n = 1'b0;
    tick();
    chk("sw_rst", 32'({a_state, a_mem_we, a_mem_req}), {4'd0, 2'b01});
    rst_n = 1'b1; mem_ready = 1'b1;

    // BEQ: 0,1,9,0
    op = 6'b000100;
    tick(); tick();
    chk("beq_branch", 32'({a_state, a_alu_op, a_pc_write_cond, a_pc_src, a_pc_write, a_alu_src_a}),
        {4'd9, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1});
    tick(); chk("beq_done", 32'(a_state), 32'd0);

    // JAL: 0,1,10,0
    op = 6'b000011;
    tick(); tick();
    chk("jal_jump", 32'({a_state, a_pc_write, a_pc_src, a_link, a_reg_write}), {4'd10, 5'b11011});
    tick(); chk("jal_done", 32'(a_state), 32'd0);

    // ORI, checked on the wide build too
    op = 6'b001101;
    tick(); tick();
    chk("ori_exec", 32'({a_state, a_alu_op, a_extend_op, a_alu_src_b}), {4'd3, 2'b10, 1'b0, 2'b10});
    chk("ori_wide_aluop", 32'({b_alu_op, b_extend_op}), {4'b0010, 1'b0});
    tick();
    chk("ori_wb", 32'({a_state, a_reg_write, a_reg_dst}), {4'd8, 2'b10});
    tick(); chk("ori_done", 32'(a_state), 32'd0);

    // Illegal opcode traps until reset
    op = 6'b111111;
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      chk("trap_hold", 32'({a_state, a_illegal_op, a_mem_req, a_reg_write, a_pc_write,
                            a_ir_write, a_pc_write_cond, a_mem_we}), {4'd15, 7'b1000000});
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("trap_rst", 32'({a_state, a_illegal_op}), {4'd0, 1'b0});
    rst_n = 1'b1; op = 6'b000000;
    tick();
    chk("post_trap", 32'({a_state, a_illegal_op}), {4'd1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
